fetch_stage: RTL

//  Instruction fetch stage plus IF/ID pipeline register, directly upstream of control_unit.

---
 rtl/fetch_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage : instruction fetch + IF/ID pipeline register
//
// Holds the PC and fetches from instruction memory over a req/ready
// handshake. Each completed fetch is registered as {instruction, PC+4} for
// decode, and the top six instruction bits go to control_unit. Hazard stalls
// and branch/jump redirects (which flush IF/ID) arrive from later stages.
//
// Ports
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_stall           hold IF/ID, no new capture into IF/ID
//   i_redirect        load i_redirect_pc into the PC and flush IF/ID
//   i_redirect_pc     redirect target, bits [1:0] forced to 00
//   o_imem_req        fetch request valid
//   o_imem_addr       fetch address (the PC register)
//   i_imem_ready      memory completes the request this cycle
//   i_imem_rdata      instruction word, valid with o_imem_req && i_imem_ready
//   o_id_valid        IF/ID holds a live instruction
//   o_id_inst         IF/ID instruction
//   o_id_opcode       o_id_inst[31:26]
//   o_id_pc4          PC of o_id_inst + 4
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter int              PC_W     = 64,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_stall,
   input  logic            i_redirect,
   input  logic [PC_W-1:0] i_redirect_pc,
   output logic            o_imem_req,
   output logic [PC_W-1:0] o_imem_addr,
   input  logic            i_imem_ready,
   input  logic [31:0]     i_imem_rdata,
   output logic            o_id_valid,
   output logic [31:0]     o_id_inst,
   output logic [5:0]      o_id_opcode,
   output logic [PC_W-1:0] o_id_pc4
);

   // BOOT : one idle cycle after reset
   // REQ  : request outstanding, response goes to IF/ID (or hold)
   // DROP : request outstanding, response is discarded (redirect pending)
   // HELD : response captured while stalled, waiting to enter IF/ID
   typedef enum logic [1:0] {BOOT, REQ, DROP, HELD} state_t;

   state_t          r_state;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] r_redir;
   logic [31:0]     r_hold_inst;
   logic [PC_W-1:0] r_hold_pc4;
   logic            r_id_valid;
   logic [31:0]     r_id_inst;
   logic [PC_W-1:0] r_id_pc4;

   logic [PC_W-1:0] w_tgt;
   logic [PC_W-1:0] w_pc4;

   // Word-align the target by masking, so every target bit is consumed.
   assign w_tgt = i_redirect_pc & ~PC_W'(3);
   assign w_pc4 = r_pc + PC_W'(4);   // wraps modulo 2^PC_W

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= BOOT;
         r_pc        <= RESET_PC;
         r_redir     <= '0;
         r_hold_inst <= '0;
         r_hold_pc4  <= '0;
         r_id_valid  <= 1'b0;
         r_id_inst   <= '0;
         r_id_pc4    <= '0;
      end else begin
         case (r_state)
            BOOT: r_state <= REQ;
            REQ: begin
               if (i_imem_ready) begin
                  if (i_redirect) begin
                     // Response belongs to the wrong path: drop it.
                     r_pc       <= w_tgt;
                     r_id_valid <= 1'b0;
                     r_id_inst  <= '0;
                     r_id_pc4   <= '0;
                  end else if (!i_stall) begin
                     r_id_valid <= 1'b1;
                     r_id_inst  <= i_imem_rdata;
                     r_id_pc4   <= w_pc4;
                     r_pc       <= w_pc4;
                  end else begin
                     // Decode is stalled; park the word instead of losing it.
                     r_hold_inst <= i_imem_rdata;
                     r_hold_pc4  <= w_pc4;
                     r_pc        <= w_pc4;
                     r_state     <= HELD;
                  end
               end else if (i_redirect) begin
                  // Address must stay stable until ready, so remember the
                  // target and discard the in-flight response later.
                  r_redir    <= w_tgt;
                  r_id_valid <= 1'b0;
                  r_id_inst  <= '0;
                  r_id_pc4   <= '0;
                  r_state    <= DROP;
               end
            end
            DROP: begin
               if (i_imem_ready) begin
                  r_pc    <= i_redirect ? w_tgt : r_redir;
                  r_state <= REQ;
               end else if (i_redirect) begin
                  r_redir <= w_tgt;
               end
               if (i_redirect) begin
                  r_id_valid <= 1'b0;
                  r_id_inst  <= '0;
                  r_id_pc4   <= '0;
               end
            end
            HELD: begin
               if (i_redirect) begin
                  r_pc       <= w_tgt;
                  r_id_valid <= 1'b0;
                  r_id_inst  <= '0;
                  r_id_pc4   <= '0;
                  r_state    <= REQ;
               end else if (!i_stall) begin
                  r_id_valid <= 1'b1;
                  r_id_inst  <= r_hold_inst;
                  r_id_pc4   <= r_hold_pc4;
                  r_state    <= REQ;
               end
            end
            default: r_state <= BOOT;
         endcase
      end
   end

   assign o_imem_req  = (r_state == REQ) || (r_state == DROP);
   assign o_imem_addr = r_pc;
   assign o_id_valid  = r_id_valid;
   assign o_id_inst   = r_id_inst;
   assign o_id_opcode = r_id_inst[31:26];
   assign o_id_pc4    = r_id_pc4;

endmodule
